// File: rtl/dac_update_scheduler_if.sv
// Write-request bus between the two code requesters (host/config, delay sequencer)
// and the DAC update scheduler. Requester r uses bit r / field r of each vector.
interface dac_update_scheduler_if;
   logic [1:0]  i_req_valid;
   logic [1:0]  o_req_ready;
   logic [3:0]  i_req_ch;
   logic [15:0] i_req_data;

   modport master (
      output i_req_valid,
      output i_req_ch,
      output i_req_data,
      input  o_req_ready
   );

   modport slave (
      input  i_req_valid,
      input  i_req_ch,
      input  i_req_data,
      output o_req_ready
   );
endinterface

// File: rtl/dac_update_scheduler.sv
// Shadows the four 8-bit DAC channel codes, arbitrates writes from two requesters
// round-robin, and launches a serializer frame whenever a channel is dirty or forced.
//
// state      | meaning
// IDLE       | no frame in progress; waits for a dirty channel or a pending force
// LOAD       | one cycle: snapshot shadow into o_dac_data, clear dirty, arm CS timer
// CS_LOW     | o_dac_cs held low while the timer runs down
// WAIT_FRAME | o_dac_cs high, serializer finishing its 4-word sequence
module dac_update_scheduler #(
   parameter int CS_LOW_CYCLES = 40,
   parameter int FRAME_CYCLES  = 2400,
   parameter int CNT_W         = 12
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   dac_update_scheduler_if.slave req,
   input  logic                  i_force_update,
   output logic [31:0]           o_dac_data,
   output logic                  o_dac_cs,
   output logic                  o_busy,
   output logic [3:0]            o_pending
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_CS_LOW,
      ST_WAIT_FRAME
   } state_t;

   localparam logic [CNT_W-1:0] CS_LOAD    = CNT_W'(CS_LOW_CYCLES - 1);
   localparam logic [CNT_W-1:0] FRAME_LOAD = CNT_W'(FRAME_CYCLES - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       shadow_q [4];
   logic [3:0]       dirty_q, dirty_d;
   logic             force_q, force_d;
   logic             rr_ptr_q, rr_ptr_d;
   logic [31:0]      data_q;
   logic             cs_q;

   logic [1:0]       grant;
   logic             wr_en;
   logic             wr_sel;
   logic [1:0]       wr_ch;
   logic [7:0]       wr_data;
   logic [3:0]       wr_mask;

   // Pointer names the requester that wins the next contested cycle.
   always_comb begin
      grant    = 2'b00;
      rr_ptr_d = rr_ptr_q;
      case (req.i_req_valid)
         2'b01: grant = 2'b01;
         2'b10: grant = 2'b10;
         2'b11: begin
            grant    = rr_ptr_q ? 2'b10 : 2'b01;
            rr_ptr_d = ~rr_ptr_q;
         end
         default: grant = 2'b00;
      endcase
      if (!i_rst_n) begin
         grant = 2'b00;
      end
   end

   always_comb begin
      wr_en   = |grant;
      wr_sel  = grant[1];
      wr_ch   = wr_sel ? req.i_req_ch[3:2]   : req.i_req_ch[1:0];
      wr_data = wr_sel ? req.i_req_data[15:8] : req.i_req_data[7:0];
      wr_mask = wr_en ? (4'b0001 << wr_ch) : 4'b0000;
   end

   assign req.o_req_ready = grant;

   // A write landing on the LOAD edge keeps its dirty bit so it rides the next frame.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dirty_d = dirty_q | wr_mask;
      force_d = force_q | i_force_update;
      case (state_q)
         ST_IDLE: begin
            if ((|dirty_q) || force_q) begin
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            dirty_d = wr_mask;
            force_d = i_force_update;
            cnt_d   = CS_LOAD;
            state_d = ST_CS_LOW;
         end
         ST_CS_LOW: begin
            if (cnt_q == '0) begin
               cnt_d   = FRAME_LOAD;
               state_d = ST_WAIT_FRAME;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_WAIT_FRAME: begin
            if (cnt_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         dirty_q  <= '0;
         force_q  <= 1'b0;
         rr_ptr_q <= 1'b0;
         data_q   <= '0;
         cs_q     <= 1'b1;
         for (int k = 0; k < 4; k++) begin
            shadow_q[k] <= '0;
         end
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         dirty_q  <= dirty_d;
         force_q  <= force_d;
         rr_ptr_q <= rr_ptr_d;
         cs_q     <= (state_d != ST_CS_LOW);
         if (state_q == ST_LOAD) begin
            data_q <= {shadow_q[3], shadow_q[2], shadow_q[1], shadow_q[0]};
         end
         if (wr_en) begin
            shadow_q[wr_ch] <= wr_data;
         end
      end
   end

   assign o_dac_data = data_q;
   assign o_dac_cs   = cs_q;
   assign o_busy     = (state_q != ST_IDLE);
   assign o_pending  = dirty_q;

endmodule

// File: tb/tb_dac_update_scheduler.sv
// Bench for dac_update_scheduler: frame-timeline model checked every cycle on the
// falling edge, plus directed scenarios with literal expected values.
module tb_dac_update_scheduler;
   localparam int CS_LOW = 40;
   localparam int FRAME  = 2400;
   localparam int FULL   = 1 + CS_LOW + FRAME;

   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        i_force_update = 1'b0;
   logic [31:0] o_dac_data;
   logic        o_dac_cs;
   logic        o_busy;
   logic [3:0]  o_pending;

   dac_update_scheduler_if req_if ();

   dac_update_scheduler #(
      .CS_LOW_CYCLES(CS_LOW),
      .FRAME_CYCLES (FRAME),
      .CNT_W        (12)
   ) dut (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .req           (req_if),
      .i_force_update(i_force_update),
      .o_dac_data    (o_dac_data),
      .o_dac_cs      (o_dac_cs),
      .o_busy        (o_busy),
      .o_pending     (o_pending)
   );

   always #5 i_clk = ~i_clk;

   int n_checks = 0;
   int n_err    = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: m_pos is the position inside the current frame (0 = LOAD cycle), -1 when idle.
   logic [7:0]  m_shadow [4];
   logic [3:0]  m_dirty;
   logic        m_force;
   logic        m_ptr;
   logic        m_on = 1'b0;
   logic [31:0] m_data;
   int          m_pos;

   always @(negedge i_clk) begin : compare
      logic [1:0] v;
      logic [1:0] er;
      logic       go;
      int         sel;
      int         ch;
      v  = req_if.i_req_valid;
      er = 2'b00;
      if (i_rst_n) begin
         if (v == 2'b01)      er = 2'b01;
         else if (v == 2'b10) er = 2'b10;
         else if (v == 2'b11) er = m_ptr ? 2'b10 : 2'b01;
      end
      if (m_on) begin
         chk("ready",   32'(req_if.o_req_ready), 32'(er));
         chk("data",    o_dac_data, m_data);
         chk("cs",      32'(o_dac_cs), 32'(!(m_pos >= 1 && m_pos <= CS_LOW)));
         chk("busy",    32'(o_busy), 32'(m_pos >= 0));
         chk("pending", 32'(o_pending), 32'(m_dirty));
      end
      if (!i_rst_n) begin
         for (int k = 0; k < 4; k++) m_shadow[k] = 8'h00;
         m_dirty = 4'b0000;
         m_force = 1'b0;
         m_ptr   = 1'b0;
         m_data  = 32'h0;
         m_pos   = -1;
         m_on    = 1'b1;
      end else if (m_on) begin
         go = (m_pos < 0) && ((|m_dirty) || m_force);
         if (m_pos == 0) begin
            m_data  = {m_shadow[3], m_shadow[2], m_shadow[1], m_shadow[0]};
            m_dirty = 4'b0000;
            m_force = 1'b0;
         end
         if (er != 2'b00) begin
            sel = er[1] ? 1 : 0;
            ch  = int'(req_if.i_req_ch[2*sel +: 2]);
            m_shadow[ch] = req_if.i_req_data[8*sel +: 8];
            m_dirty[ch]  = 1'b1;
         end
         if (v == 2'b11) m_ptr = ~m_ptr;
         if (i_force_update) m_force = 1'b1;
         if (go) begin
            m_pos = 0;
         end else if (m_pos >= 0) begin
            m_pos++;
            if (m_pos >= FULL) m_pos = -1;
         end
      end
   end

   task automatic cyc();
      @(posedge i_clk);
      #1;
   endtask

   task automatic wait_busy(input logic val, input int budget, input string name);
      int n;
      n = 0;
      while (o_busy !== val && n < budget) begin
         cyc();
         n++;
      end
      chk(name, 32'(o_busy), 32'(val));
   endtask

   task automatic wait_cs_low(input int budget, input string name);
      int n;
      n = 0;
      while (o_dac_cs !== 1'b0 && n < budget) begin
         cyc();
         n++;
      end
      chk(name, 32'(o_dac_cs), 32'h0);
   endtask

   task automatic put(input logic [1:0] valid, input logic [3:0] ch, input logic [15:0] d,
                      input logic [1:0] exp_ready, input string name);
      req_if.i_req_valid = valid;
      req_if.i_req_ch    = ch;
      req_if.i_req_data  = d;
      #1;
      chk(name, 32'(req_if.o_req_ready), 32'(exp_ready));
      cyc();
      req_if.i_req_valid = 2'b00;
   endtask

   initial begin : watchdog
      #600000;
      $display("FAIL watchdog: actual timeout required finish at %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int   n;
      int   ncs;
      int   bad;
      int   nload;
      logic prev;
      req_if.i_req_valid = 2'b00;
      req_if.i_req_ch    = 4'h0;
      req_if.i_req_data  = 16'h0;
      repeat (3) cyc();
      i_rst_n = 1'b1;
      chk("rst_cs",      32'(o_dac_cs), 32'h1);
      chk("rst_busy",    32'(o_busy), 32'h0);
      chk("rst_data",    o_dac_data, 32'h0);
      chk("rst_pending", 32'(o_pending), 32'h0);
      chk("rst_ready",   32'(req_if.o_req_ready), 32'h0);

      // 1: single write, frame timing
      put(2'b01, 4'b0010, 16'h00A5, 2'b01, "t1_ready");
      chk("t1_pending", 32'(o_pending), 32'h4);
      chk("t1_idle", 32'(o_busy), 32'h0);
      cyc();
      chk("t1_load", 32'(o_busy), 32'h1);
      chk("t1_load_cs", 32'(o_dac_cs), 32'h1);
      n = 0; ncs = 0;
      while (o_busy && n < FULL + 100) begin
         cyc();
         n++;
         if (!o_dac_cs) begin
            ncs++;
            chk("t1_data", o_dac_data, 32'h00A50000);
         end
      end
      chk("t1_cs_len", 32'(ncs), 32'd40);
      chk("t1_busy_len", 32'(n), 32'd2441);

      // 2: contested round-robin
      i_rst_n = 1'b0;
      cyc();
      i_rst_n = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         put(2'b11, 4'b0100, {8'(8'h20 + i), 8'(8'h10 + i)},
             (i % 2 == 1) ? 2'b01 : 2'b10, "t2_grant");
      end
      chk("t2_pending", 32'(o_pending), 32'h3);
      wait_busy(1'b0, FULL + 10, "t2_end1");
      wait_cs_low(10, "t2_cs2");
      chk("t2_data", o_dac_data, 32'h00002413);

      // 3: write during CS_LOW held for the next frame
      put(2'b01, 4'b0011, 16'h007F, 2'b01, "t3_ready");
      chk("t3_pend_bit", 32'(o_pending[3]), 32'h1);
      n = 0; bad = 0;
      while (o_busy && n < FULL) begin
         if (o_dac_data !== 32'h00002413) bad++;
         cyc();
         n++;
      end
      chk("t3_idle", 32'(o_busy), 32'h0);
      chk("t3_hold", 32'(bad), 32'h0);
      chk("t3_dirty_kept", 32'(o_pending), 32'h8);
      cyc();
      chk("t3_load", 32'(o_busy), 32'h1);
      cyc();
      chk("t3_cs", 32'(o_dac_cs), 32'h0);
      chk("t3_data_hi", 32'(o_dac_data[31:24]), 32'h7F);

      // 4: write on the LOAD edge excluded from the snapshot
      wait_busy(1'b0, FULL, "t4_idle");
      put(2'b10, 4'b0000, 16'h5500, 2'b10, "t4_ready1");
      cyc();
      chk("t4_load", 32'(o_busy), 32'h1);
      put(2'b01, 4'b0010, 16'h003C, 2'b01, "t4_ready2");
      chk("t4_pend", 32'(o_pending), 32'h4);
      chk("t4_cs", 32'(o_dac_cs), 32'h0);
      chk("t4_snap", o_dac_data, 32'h7F002455);
      wait_busy(1'b0, FULL, "t4_idle2");
      wait_cs_low(10, "t4_cs2");
      chk("t4_next", o_dac_data, 32'h7F3C2455);

      // 5: two forces during WAIT_FRAME give one extra frame
      n = 0;
      while (!o_dac_cs && n < 100) begin
         cyc();
         n++;
      end
      chk("t5_wait", 32'(o_dac_cs), 32'h1);
      i_force_update = 1'b1; cyc(); i_force_update = 1'b0;
      repeat (10) cyc();
      i_force_update = 1'b1; cyc(); i_force_update = 1'b0;
      nload = 0; bad = 0; prev = o_busy;
      for (int k = 0; k < 2 * FULL + 200; k++) begin
         cyc();
         if (o_busy && !prev) nload++;
         if (!o_dac_cs && o_dac_data !== 32'h7F3C2455) bad++;
         prev = o_busy;
      end
      chk("t5_frames", 32'(nload), 32'h1);
      chk("t5_data", 32'(bad), 32'h0);
      chk("t5_pend", 32'(o_pending), 32'h0);

      // 6: reset mid-CS_LOW
      put(2'b10, 4'b0100, 16'h9900, 2'b10, "t6_ready");
      wait_cs_low(10, "t6_cs");
      repeat (5) cyc();
      i_rst_n = 1'b0;
      cyc();
      chk("t6_cs", 32'(o_dac_cs), 32'h1);
      chk("t6_data", o_dac_data, 32'h0);
      chk("t6_pending", 32'(o_pending), 32'h0);
      chk("t6_busy", 32'(o_busy), 32'h0);
      i_rst_n = 1'b1;
      bad = 0;
      repeat (100) begin
         cyc();
         if (o_busy) bad++;
      end
      chk("t6_quiet", 32'(bad), 32'h0);

      repeat (3) cyc();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
